share_sequencer: RTL and testbench

SHARE_SEQUENCER -- requirements
Module: share_sequencer

---
 rtl/share_sequencer.sv | 133 +++++++++++++
 tb/tb_share_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/share_sequencer.sv
// Column-wise Boolean masking sequencer: splits a 320-bit state into d+1 shares, one column per PRNG transfer.
// Optional build macro SHARE_SEQUENCER_ZEROIZE_EN clears shr_data after each share handshake and on abort.
package ascon_params;
  parameter int d        = 2;
  parameter int COL_SIZE = 5;
  parameter int PAR      = 1;
endpackage

module share_sequencer
  import ascon_params::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                data_valid,
  output logic                                data_ready,
  input  logic [COL_SIZE*PAR-1:0]             data_in,
  output logic                                rnd_req,
  input  logic                                rnd_valid,
  input  logic [d*COL_SIZE*PAR-1:0]           rnd_data,
  output logic                                shr_valid,
  input  logic                                shr_ready,
  output logic [(d+1)*COL_SIZE*PAR-1:0]       shr_data,
  output logic [$clog2(64/PAR)-1:0]           shr_col,
  output logic                                busy,
  output logic                                done
);

  localparam int W        = COL_SIZE * PAR;
  localparam int NUM_COLS = 64 / PAR;
  localparam int CW       = $clog2(NUM_COLS);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, WAIT_RND, OUTPUT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          col_cnt_q, col_cnt_d;
  logic [W-1:0]           data_q, data_d;
  logic [(d+1)*W-1:0]     shr_data_q, shr_data_d;
  logic                   done_q, done_d;
  logic                   last_col;

  // mask_acc[d] is the plaintext folded with every mask, i.e. share 0
  logic [d:0][W-1:0]      mask_acc;

  assign mask_acc[0] = data_q;

  generate
    for (genvar gi = 0; gi < d; gi++) begin : g_mask_fold
      assign mask_acc[gi+1] = mask_acc[gi] ^ rnd_data[gi*W +: W];
    end
  endgenerate

  assign last_col = (col_cnt_q == CW'(NUM_COLS - 1));

  always_comb begin
    state_d    = state_q;
    col_cnt_d  = col_cnt_q;
    data_d     = data_q;
    shr_data_d = shr_data_q;
    done_d     = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      col_cnt_d = '0;
`ifdef SHARE_SEQUENCER_ZEROIZE_EN
      shr_data_d = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = WAIT_DATA;
            col_cnt_d = '0;
          end
        end
        WAIT_DATA: begin
          if (data_valid) begin
            data_d  = data_in;
            state_d = WAIT_RND;
          end
        end
        WAIT_RND: begin
          if (rnd_valid) begin
            shr_data_d = {rnd_data, mask_acc[d]};
            state_d    = OUTPUT;
          end
        end
        OUTPUT: begin
          if (shr_ready) begin
`ifdef SHARE_SEQUENCER_ZEROIZE_EN
            shr_data_d = '0;
`endif
            if (last_col) begin
              state_d   = IDLE;
              col_cnt_d = '0;
              done_d    = 1'b1;
            end else begin
              state_d   = WAIT_DATA;
              col_cnt_d = col_cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_cnt_q  <= '0;
      data_q     <= '0;
      shr_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_cnt_q  <= col_cnt_d;
      data_q     <= data_d;
      shr_data_q <= shr_data_d;
      done_q     <= done_d;
    end
  end

  // handshake strobes are pure state decodes so reset clears them combinationally
  assign data_ready = (state_q == WAIT_DATA);
  assign rnd_req    = (state_q == WAIT_RND);
  assign shr_valid  = (state_q == OUTPUT);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign shr_data   = shr_data_q;
  assign shr_col    = col_cnt_q;

endmodule

// File: tb/tb_share_sequencer.sv
// Randomised bench for share_sequencer: transaction-level model plus plaintext scoreboard and literal pins.
module tb_share_sequencer;
  import ascon_params::*;

  localparam int W  = COL_SIZE * PAR;
  localparam int NC = 64 / PAR;
  localparam int CW = $clog2(NC);
  localparam int SW = (d + 1) * W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            data_valid = 1'b0;
  logic            rnd_valid = 1'b0;
  logic            shr_ready = 1'b0;
  logic [W-1:0]    data_in = '0;
  logic [d*W-1:0]  rnd_data = '0;
  logic            data_ready, rnd_req, shr_valid, busy, done;
  logic [SW-1:0]   shr_data;
  logic [CW-1:0]   shr_col;

  share_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .rnd_req(rnd_req), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .shr_valid(shr_valid), .shr_ready(shr_ready), .shr_data(shr_data),
    .shr_col(shr_col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model: which handshake the sequencer is waiting for (0 none, 1 data, 2 rnd, 3 share)
  int            m_phase;
  int            m_col;
  logic [W-1:0]  m_data;
  logic [SW-1:0] m_shr;
  bit            m_done;
  logic [W-1:0]  pt_q[$];
  int            hs_count = 0;
  int            done_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] encode(input logic [W-1:0] pt, input logic [d*W-1:0] r);
    logic [SW-1:0] o;
    logic [W-1:0]  s0;
    s0 = pt;
    o  = '0;
    for (int i = 0; i < d; i++) begin
      s0 ^= r[i*W +: W];
      o[(i+1)*W +: W] = r[i*W +: W];
    end
    o[0 +: W] = s0;
    return o;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_col   = 0;
    m_data  = '0;
    m_shr   = '0;
    m_done  = 1'b0;
    pt_q.delete();
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (abort) begin
      m_phase = 0;
      m_col   = 0;
`ifdef SHARE_SEQUENCER_ZEROIZE_EN
      m_shr = '0;
`endif
      pt_q.delete();
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        m_col   = 0;
      end
    end else if (m_phase == 1) begin
      if (data_valid) begin
        m_data = data_in;
        pt_q.push_back(data_in);
        m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (rnd_valid) begin
        m_shr   = encode(m_data, rnd_data);
        m_phase = 3;
      end
    end else if (shr_ready) begin
`ifdef SHARE_SEQUENCER_ZEROIZE_EN
      m_shr = '0;
`endif
      if (m_col == NC - 1) begin
        m_phase = 0;
        m_done  = 1'b1;
      end else begin
        m_col++;
        m_phase = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("data_ready", 64'(data_ready), 64'(m_phase == 1));
    chk("rnd_req",    64'(rnd_req),    64'(m_phase == 2));
    chk("shr_valid",  64'(shr_valid),  64'(m_phase == 3));
    chk("busy",       64'(busy),       64'(m_phase != 0));
    chk("done",       64'(done),       64'(m_done));
    chk("shr_data",   64'(shr_data),   64'(m_shr));
    if (m_phase == 3) chk("shr_col", 64'(shr_col), 64'(m_col));
    if (done === 1'b1) done_count++;
  endtask

  // called at a negedge with inputs already applied; returns at the next negedge
  task automatic step();
    logic [W-1:0] x;
    if (shr_valid === 1'b1 && shr_ready && !abort) begin
      x = '0;
      for (int i = 0; i <= d; i++) x ^= shr_data[i*W +: W];
      chk("share_inflight", 64'(pt_q.size()), 64'(1));
      if (pt_q.size() > 0) chk("share_xor", 64'(x), 64'(pt_q.pop_front()));
      hs_count++;
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; data_valid = 0; rnd_valid = 0; shr_ready = 0;
  endtask

  initial begin
    int hs0;
    bit seen;
    logic [SW-1:0] lit;

    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_shr_data", 64'(shr_data), 64'(0));
    rst_n = 1'b1;
    step();

    // first column with the hand-encoded vector, then a stall with an ignored start
    start = 1; step();
    start = 0; data_valid = 1; data_in = 5'b10110; step();
    data_valid = 0; rnd_valid = 1; rnd_data = 10'b00011_11001; step();
    lit = 15'b00011_11001_01100;
    chk("lit_valid", 64'(shr_valid), 64'(1));
    chk("lit_data", 64'(shr_data), 64'(lit));
    chk("lit_col", 64'(shr_col), 64'(0));
    rnd_valid = 0; shr_ready = 0; start = 1; step();
    start = 0;
    repeat (4) step();
    chk("stall_data", 64'(shr_data), 64'(lit));
    chk("stall_rnd_req", 64'(rnd_req), 64'(0));
    shr_ready = 1; step();
`ifdef SHARE_SEQUENCER_ZEROIZE_EN
    chk("zeroize_after_hs", 64'(shr_data), 64'(0));
`else
    chk("hold_after_hs", 64'(shr_data), 64'(lit));
`endif
    chk("col1_ready", 64'(data_ready), 64'(1));
    shr_ready = 0; abort = 1; step();
    abort = 0;
    chk("abort_busy", 64'(busy), 64'(0));

    // PRNG starvation
    start = 1; step();
    start = 0; data_valid = 1; data_in = W'($urandom); step();
    data_valid = 0;
    repeat (10) step();
    chk("starve_rnd_req", 64'(rnd_req), 64'(1));
    chk("starve_no_ready", 64'(data_ready), 64'(0));
    rnd_valid = 1; rnd_data = (d*W)'($urandom); step();
    rnd_valid = 0; shr_ready = 1; step();
    shr_ready = 0; abort = 1; step();
    abort = 0;

    // full-rate run of all columns
    start = 1; step();
    start = 0; data_valid = 1; rnd_valid = 1; shr_ready = 1;
    done_count = 0; hs0 = hs_count; seen = 0;
    for (int c = 0; c < NC * 3 + 20 && !seen; c++) begin
      data_in = W'($urandom); rnd_data = (d*W)'($urandom);
      step();
      if (done === 1'b1) begin
        seen = 1;
        chk("done_busy_low", 64'(busy), 64'(0));
      end
    end
    chk("done_seen", 64'(seen), 64'(1));
    idle_inputs();
    repeat (3) step();
    chk("done_once", 64'(done_count), 64'(1));
    chk("cols_done", 64'(hs_count - hs0), 64'(NC));

    // abort while waiting for randomness of column 17
    start = 1; step();
    start = 0; data_valid = 1; rnd_valid = 0; shr_ready = 1; seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      data_in = W'($urandom); rnd_data = (d*W)'($urandom);
      rnd_valid = (m_phase == 2 && m_col == 17) ? 1'b0 : 1'b1;
      if (m_phase == 2 && m_col == 17) seen = 1;
      else step();
    end
    chk("reached_col17", 64'(seen), 64'(1));
    chk("col17_waiting", 64'(rnd_req), 64'(1));
    abort = 1; step();
    idle_inputs();
    chk("abort17_busy", 64'(busy), 64'(0));
    chk("abort17_done", 64'(done), 64'(0));
    step();
    chk("abort17_no_done", 64'(done), 64'(0));
    start = 1; step();
    start = 0; data_valid = 1; data_in = W'($urandom); step();
    data_valid = 0; rnd_valid = 1; rnd_data = (d*W)'($urandom); step();
    rnd_valid = 0;
    chk("restart_col", 64'(shr_col), 64'(0));
    chk("restart_valid", 64'(shr_valid), 64'(1));
    abort = 1; step();
    abort = 0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      start      = (m_phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      abort      = ($urandom_range(0, 199) == 0);
      data_valid = $urandom_range(0, 1);
      rnd_valid  = ($urandom_range(0, 2) != 0);
      shr_ready  = $urandom_range(0, 1);
      data_in    = W'($urandom);
      rnd_data   = (d*W)'($urandom);
      step();
    end
    idle_inputs();
    abort = 1; step();
    abort = 0;

    // asynchronous reset while presenting shares
    start = 1; step();
    start = 0; data_valid = 1; data_in = W'($urandom); step();
    data_valid = 0; rnd_valid = 1; rnd_data = (d*W)'($urandom); step();
    rnd_valid = 0;
    chk("pre_rst_valid", 64'(shr_valid), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(shr_valid), 64'(0));
    chk("arst_rnd_req", 64'(rnd_req), 64'(0));
    chk("arst_ready", 64'(data_ready), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_data", 64'(shr_data), 64'(0));
    chk("arst_col", 64'(shr_col), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
